// File: rtl/reg_dump_pkg.sv
// Shared types and defaults for the register-file dump engine.
package reg_dump_pkg;
  localparam int N_DEF     = 8;
  localparam int NREGS_DEF = 32;

  typedef enum logic [2:0] {IDLE, READ, SEND, FIN, CSUM} state_t;
endpackage

// File: rtl/reg_dump_reader_if.sv
// Beat stream from the dump engine to its debug/trace sink.
interface reg_dump_reader_if #(
  parameter int N  = 8,
  parameter int AW = 5
);
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;
  logic [AW-1:0] out_addr;
  logic          out_last;

  modport master (output out_valid, out_data, out_addr, out_last, input out_ready);
  modport slave  (input out_valid, out_data, out_addr, out_last, output out_ready);
endinterface

// File: rtl/dump_beat_reg.sv
// Enable-loaded holding register for one output beat {data, addr, last}.
module dump_beat_reg #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end
endmodule

// File: rtl/reg_dump_reader.sv
// Register-file dump engine: walks every register and streams it out as beats.
// Optional REG_DUMP_CHECKSUM_EN appends an XOR checksum beat after the last register.
module reg_dump_reader
  import reg_dump_pkg::*;
#(
  parameter  int N     = N_DEF,
  parameter  int NREGS = NREGS_DEF,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] rf_raddr,
  input  logic [N-1:0]  rf_rdata,
  reg_dump_reader_if.master dout
);
  state_t        state, nxt;
  logic [AW-1:0] idx;
  logic          is_last;
  logic          accept;
  logic          ld;
  logic          last_flag;
  logic [N+AW:0] beat_d, beat_q;

  assign is_last  = (idx == AW'(NREGS - 1));
  assign accept   = dout.out_valid && dout.out_ready;
  assign rf_raddr = idx;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (start) nxt = READ;
      READ: nxt = SEND;
      SEND: if (accept) begin
`ifdef REG_DUMP_CHECKSUM_EN
        nxt = is_last ? CSUM : READ;
`else
        nxt = is_last ? FIN : READ;
`endif
      end
      CSUM: if (accept) nxt = FIN;
      FIN:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Index stops at NREGS-1: the final beat leaves the counter untouched.
  always_ff @(posedge clk) begin
    if (rst)                          idx <= '0;
    else if (state == IDLE && start)  idx <= '0;
    else if (state == SEND && accept && !is_last) idx <= idx + AW'(1);
  end

`ifdef REG_DUMP_CHECKSUM_EN
  logic [N-1:0] acc;

  always_ff @(posedge clk) begin
    if (rst)                         acc <= '0;
    else if (state == IDLE && start) acc <= '0;
    else if (state == READ)          acc <= acc ^ rf_rdata;
  end

  // The checksum beat owns the last flag, so register beats never carry it.
  assign last_flag = 1'b0;
  assign ld        = (state == READ) || (state == SEND && accept && is_last);
  assign beat_d    = (state == READ) ? {rf_rdata, idx, last_flag} : {acc, {AW{1'b0}}, 1'b1};
`else
  assign last_flag = is_last;
  assign ld        = (state == READ);
  assign beat_d    = {rf_rdata, idx, last_flag};
`endif

  dump_beat_reg #(.W(N + AW + 1)) u_beat (
    .clk (clk),
    .rst (rst),
    .en  (ld),
    .d   (beat_d),
    .q   (beat_q)
  );

  assign {dout.out_data, dout.out_addr, dout.out_last} = beat_q;
  assign dout.out_valid = (state == SEND) || (state == CSUM);
  assign busy           = (state != IDLE);
  assign done           = (state == FIN);
endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader; build with REG_DUMP_CHECKSUM_EN to cover the checksum beat.
module tb_reg_dump_reader;
  localparam int N     = 8;
  localparam int NREGS = 32;
  localparam int AW    = 5;
`ifdef REG_DUMP_CHECKSUM_EN
  localparam int NB = NREGS + 1;
`else
  localparam int NB = NREGS;
`endif

  logic          clk = 1'b0;
  logic          rst, start, busy, done;
  logic [AW-1:0] rf_raddr;
  logic [N-1:0]  rf_rdata;
  logic [7:0]    rf [NREGS];

  reg_dump_reader_if #(.N(N), .AW(AW)) dif ();

  reg_dump_reader #(.N(N), .NREGS(NREGS)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .rf_raddr (rf_raddr),
    .rf_rdata (rf_rdata),
    .dout     (dif)
  );

  always #5 clk = ~clk;
  assign rf_rdata = rf[rf_raddr];

  int n_cmp = 0, n_err = 0;
  int ncyc = 0;
  int k, done_cnt, done_cyc;
  logic [7:0]    bd [$];
  logic [AW-1:0] ba [$];
  logic          bl [$];
  int            bc [$];

  always @(posedge clk) ncyc = ncyc + 1;

  // A beat transfers at the next rising edge when valid && ready at the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (dif.out_valid && dif.out_ready) begin
        bd.push_back(dif.out_data);
        ba.push_back(dif.out_addr);
        bl.push_back(dif.out_last);
        bc.push_back(ncyc + 1);
      end
      if (done) begin
        done_cnt = done_cnt + 1;
        done_cyc = ncyc + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clr_log();
    bd.delete(); ba.delete(); bl.delete(); bc.delete();
    done_cnt = 0;
    done_cyc = -1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_valid"}, dif.out_valid, 0);
    chk({tag, "_data"},  dif.out_data, 0);
    chk({tag, "_addr"},  dif.out_addr, 0);
    chk({tag, "_last"},  dif.out_last, 0);
  endtask

  // mode 0: ready=1; mode 1: beat 4 stalled 5 cycles, random ready elsewhere;
  // mode 2: ready=1 with a second start pulse during beat 7.
  task automatic do_dump(input int mode, input string nm);
    int hold = 0;
    logic [7:0] csum = 8'h00;
    logic [7:0] exp_d;
    logic [AW-1:0] exp_a;
    for (int i = 0; i < NREGS; i++) csum = csum ^ rf[i];
    clr_log();
    dif.out_ready = (mode != 1);
    k = ncyc + 1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 0; t < 1000 && done_cnt == 0; t++) begin
      case (mode)
        1: begin
          if (hold == 0 && dif.out_valid && dif.out_addr == 4) hold = 1;
          if (hold >= 1 && hold <= 5) begin
            chk({nm, "_hold_valid"}, dif.out_valid, 1);
            chk({nm, "_hold_data"},  dif.out_data, 8'h0D);
            chk({nm, "_hold_addr"},  dif.out_addr, 4);
            dif.out_ready = 1'b0;
            hold++;
          end else dif.out_ready = 1'($urandom_range(0, 1));
        end
        2: begin
          dif.out_ready = 1'b1;
          start = dif.out_valid && (dif.out_addr == 7);
        end
        default: dif.out_ready = 1'b1;
      endcase
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (done_cnt == 0) chk({nm, "_timeout"}, 0, 1);
    repeat (4) @(posedge clk);
    #1;
    chk({nm, "_idle_busy"}, busy, 0);
    chk({nm, "_done_cnt"},  done_cnt, 1);
    chk({nm, "_beats"},     bd.size(), NB);
    for (int i = 0; i < bd.size() && i < NB; i++) begin
      exp_d = (i < NREGS) ? rf[i] : csum;
      exp_a = (i < NREGS) ? AW'(i) : '0;
      chk($sformatf("%s_data%0d", nm, i), bd[i], exp_d);
      chk($sformatf("%s_addr%0d", nm, i), ba[i], exp_a);
      chk($sformatf("%s_last%0d", nm, i), bl[i], (i == NB - 1));
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b1;
    dif.out_ready = 1'b1;
    for (int i = 0; i < NREGS; i++) rf[i] = 8'((3 * i + 1) % 256);
    clr_log();

    // Reset with start and ready high must leave everything idle.
    repeat (2) begin
      @(posedge clk); #1;
      chk_idle("rst");
    end
    rst = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    chk_idle("post_rst");
    chk("post_rst_nobeat", bd.size(), 0);

    // Full dump with ready held high, including beat and done timing.
    do_dump(0, "full");
    for (int i = 0; i < 4; i++) chk($sformatf("full_pat%0d", i), bd[i], 8'(3 * i + 1));
    if (bc.size() >= NREGS) begin
      chk("full_t_first", bc[0], k + 2);
      chk("full_t_b1",    bc[1], k + 4);
      chk("full_t_last",  bc[NREGS-1], k + 2 * NREGS);
    end
`ifdef REG_DUMP_CHECKSUM_EN
    chk("full_t_done", done_cyc, k + 2 * NREGS + 2);
`else
    chk("full_t_done", done_cyc, k + 2 * NREGS + 1);
`endif

    do_dump(1, "bp");
    do_dump(2, "busy_start");

    // Reset during SEND of beat 10 aborts; the next dump restarts at index 0.
    clr_log();
    dif.out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 0; t < 200 && !(dif.out_valid && dif.out_addr == 10); t++) begin
      @(posedge clk); #1;
    end
    chk("abort_reach_b10", dif.out_valid && (dif.out_addr == 10), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_valid", dif.out_valid, 0);
    chk("abort_busy",  busy, 0);
    chk("abort_addr",  dif.out_addr, 0);
    rst = 1'b0;
    clr_log();
    repeat (3) @(posedge clk);
    #1;
    chk("abort_nobeat", bd.size(), 0);
    chk("abort_still_idle", busy, 0);
    do_dump(0, "after_abort");

    // Checksum pattern: XOR of 0x0F, 0xF0, 0x11 is 0xEE.
    for (int i = 0; i < NREGS; i++) rf[i] = 8'h00;
    rf[3] = 8'h0F;
    rf[7] = 8'hF0;
    rf[9] = 8'h11;
    do_dump(0, "csum");
`ifdef REG_DUMP_CHECKSUM_EN
    if (bd.size() == NREGS + 1) begin
      chk("csum_final_data", bd[NREGS], 8'hEE);
      chk("csum_final_addr", ba[NREGS], 0);
      chk("csum_final_last", bl[NREGS], 1);
      chk("csum_b31_last",   bl[NREGS-1], 0);
    end
`else
    if (bd.size() == NREGS) begin
      chk("csum_b31_last", bl[NREGS-1], 1);
      chk("csum_b9_data",  bd[9], 8'h11);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
